// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the central PCI request/grant arbiter.
package pci_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT_WAIT = 3'd1,
    BUSY     = 3'd2,
    BUSY_GNT = 3'd3,
    TURN     = 3'd4
  } arb_state_t;

  // Wide enough for MAX_WAIT up to 255.
  localparam int WAIT_W = 8;

  function automatic int owner_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic bus_idle(input logic frame_n, input logic irdy_n);
    return frame_n & irdy_n;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module pci_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         vld
);

  logic [W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        win = idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin active-low grants, FRAME#/IRDY# ownership tracking.
// Define ARB_HIDDEN_EN to allow granting the next master while the bus is still busy.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_WAIT    = 16,
  localparam int OW         = owner_width(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [OW-1:0]          owner,
  output logic                   owner_vld,
  output logic                   arb_err
);

  arb_state_t              state, state_d;
  logic [NUM_MASTERS-1:0]  gnt_d;
  logic [OW-1:0]           gidx, gidx_d;
  logic [OW-1:0]           owner_d;
  logic                    ovld_d, err_d;
  logic [OW-1:0]           ptr, ptr_d;
  logic [WAIT_W-1:0]       wait_cnt, cnt_d;
  logic                    idle_prev;
  logic                    idle_now;
  logic [OW-1:0]           pick_win;
  logic                    pick_vld;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    return (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
  endfunction

  assign idle_now = bus_idle(frame_n, irdy_n);

  pci_rr_pick #(
    .N (NUM_MASTERS),
    .W (OW)
  ) u_pick (
    .req (~req_n),
    .ptr (ptr),
    .win (pick_win),
    .vld (pick_vld)
  );

  always_comb begin
    state_d = state;
    gnt_d   = gnt_n;
    gidx_d  = gidx;
    owner_d = owner;
    ovld_d  = owner_vld;
    err_d   = 1'b0;
    ptr_d   = ptr;
    cnt_d   = wait_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_d           = '1;
          gnt_d[pick_win] = 1'b0;
          gidx_d          = pick_win;
          cnt_d           = '0;
          state_d         = GNT_WAIT;
        end else if (!frame_n) begin
          // Someone started a cycle without holding a grant.
          err_d   = 1'b1;
          ovld_d  = 1'b0;
          state_d = BUSY;
        end
      end
      GNT_WAIT: begin
        if (idle_prev && !frame_n) begin
          // Frame start takes priority over a same-edge request withdrawal.
          state_d = BUSY;
          owner_d = gidx;
          ovld_d  = 1'b1;
          gnt_d   = '1;
          ptr_d   = next_idx(gidx);
        end else if (req_n[gidx]) begin
          state_d = TURN;
          gnt_d   = '1;
        end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = TURN;
          gnt_d   = '1;
          ptr_d   = next_idx(gidx);
        end else begin
          cnt_d = wait_cnt + 1'b1;
        end
      end
      BUSY: begin
        if (idle_now) begin
          ovld_d = 1'b0;
          if (pick_vld) begin
            gnt_d           = '1;
            gnt_d[pick_win] = 1'b0;
            gidx_d          = pick_win;
            cnt_d           = '0;
            state_d         = GNT_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef ARB_HIDDEN_EN
        else if (pick_vld) begin
          gnt_d           = '1;
          gnt_d[pick_win] = 1'b0;
          gidx_d          = pick_win;
          state_d         = BUSY_GNT;
        end
`endif
      end
      BUSY_GNT: begin
`ifdef ARB_HIDDEN_EN
        if (idle_now) begin
          ovld_d = 1'b0;
          cnt_d  = '0;
          if (req_n[gidx]) begin
            gnt_d   = '1;
            state_d = TURN;
          end else begin
            state_d = GNT_WAIT;
          end
        end
`else
        gnt_d   = '1;
        state_d = IDLE;
`endif
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_n     <= '1;
      gidx      <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      arb_err   <= 1'b0;
      ptr       <= '0;
      wait_cnt  <= '0;
      idle_prev <= 1'b1;
    end else begin
      state     <= state_d;
      gnt_n     <= gnt_d;
      gidx      <= gidx_d;
      owner     <= owner_d;
      owner_vld <= ovld_d;
      arb_err   <= err_d;
      ptr       <= ptr_d;
      wait_cnt  <= cnt_d;
      idle_prev <= idle_now;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (default build, 4 masters, MAX_WAIT 16).
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       owner_vld;
  logic       arb_err;

  int checks = 0;
  int errors = 0;

  pci_bus_arbiter #(
    .NUM_MASTERS (4),
    .MAX_WAIT    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_n     (req_n),
    .frame_n   (frame_n),
    .irdy_n    (irdy_n),
    .gnt_n     (gnt_n),
    .owner     (owner),
    .owner_vld (owner_vld),
    .arb_err   (arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // At most one grant low on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ($countones(~gnt_n) <= 1) else begin
        errors++;
        $error("FAIL gnt_onehot observed=%b expected=at most one low bit", gnt_n);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_gnt", gnt_n, 4'b1111);
    chk("rst_owner", owner, 0);
    chk("rst_vld", owner_vld, 0);
    chk("rst_err", arb_err, 0);
    rst_n = 1'b1;
  endtask

  // Three-cycle transaction by master m; nxt is the grant expected at the idle edge.
  task automatic xfer(input int m, input logic [3:0] nxt);
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    chk("xfer_owner", owner, m);
    chk("xfer_vld", owner_vld, 1);
    chk("xfer_gnt_rel", gnt_n, 4'b1111);
    step();
    chk("xfer_busy_gnt", gnt_n, 4'b1111);
    frame_n = 1'b1;
    step();
    chk("xfer_last_vld", owner_vld, 1);
    irdy_n = 1'b1;
    step();
    chk("xfer_next_gnt", gnt_n, nxt);
    chk("xfer_idle_vld", owner_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    req_n   = 4'b1111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    do_reset();

    // Single grant and transaction start by master 0.
    req_n = 4'b1110;
    step();
    chk("t1_gnt0", gnt_n, 4'b1110);
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    chk("t1_owner", owner, 0);
    chk("t1_vld", owner_vld, 1);
    chk("t1_gnt_rel", gnt_n, 4'b1111);
    req_n   = 4'b1111;
    frame_n = 1'b1;
    step();
    chk("t1_vld_hold", owner_vld, 1);
    irdy_n = 1'b1;
    step();
    chk("t1_vld_drop", owner_vld, 0);
    chk("t1_idle_gnt", gnt_n, 4'b1111);
    req_n = 4'b1100;
    step();
    chk("t1_ptr_adv", gnt_n, 4'b1101);
    req_n = 4'b1111;
    step();
    chk("t1_withdraw", gnt_n, 4'b1111);
    step();

    // Round-robin among four continuous requesters.
    do_reset();
    req_n = 4'b0000;
    step();
    chk("t2_first", gnt_n, 4'b1110);
    xfer(0, 4'b1101);
    xfer(1, 4'b1011);
    xfer(2, 4'b0111);
    xfer(3, 4'b1110);

    // Asynchronous reset drops the outstanding grant without a clock edge.
    rst_n = 1'b0;
    #2;
    chk("async_rst_gnt", gnt_n, 4'b1111);
    chk("async_rst_vld", owner_vld, 0);
    req_n = 4'b1111;
    step();
    rst_n = 1'b1;

    // Master 2 never starts: grant revoked after MAX_WAIT cycles.
    req_n = 4'b0011;
    step();
    chk("t3_gnt2", gnt_n, 4'b1011);
    for (int i = 0; i < 15; i++) step();
    chk("t3_held", gnt_n, 4'b1011);
    step();
    chk("t3_revoked", gnt_n, 4'b1111);
    step();
    chk("t3_dead", gnt_n, 4'b1111);
    step();
    chk("t3_next_m3", gnt_n, 4'b0111);
    req_n = 4'b1111;
    step();
    chk("t3_withdraw", gnt_n, 4'b1111);
    step();

    // Withdrawal on the frame-start edge: frame wins.
    req_n = 4'b1101;
    step();
    chk("t4_gnt1", gnt_n, 4'b1101);
    req_n   = 4'b1111;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    chk("t4_owner", owner, 1);
    chk("t4_vld", owner_vld, 1);
    chk("t4_gnt_rel", gnt_n, 4'b1111);
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    chk("t4_end_vld", owner_vld, 0);

    // Frame without a grant.
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    chk("t5_err", arb_err, 1);
    chk("t5_vld", owner_vld, 0);
    chk("t5_gnt", gnt_n, 4'b1111);
    step();
    chk("t5_err_pulse", arb_err, 0);
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    chk("t5_err_idle", arb_err, 0);
    req_n = 4'b1110;
    step();
    chk("t5_back_idle", gnt_n, 4'b1110);
    req_n = 4'b1111;
    step();
    step();

    // No grant while the bus is busy; master 3 granted at idle.
    req_n = 4'b1110;
    step();
    chk("t6_gnt0", gnt_n, 4'b1110);
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    req_n   = 4'b0111;
    step();
    chk("t6_owner0", owner, 0);
    chk("t6_rel", gnt_n, 4'b1111);
    step();
    chk("t6_no_hidden", gnt_n, 4'b1111);
    frame_n = 1'b1;
    step();
    chk("t6_no_hidden2", gnt_n, 4'b1111);
    irdy_n = 1'b1;
    step();
    chk("t6_gnt3", gnt_n, 4'b0111);
    chk("t6_vld_drop", owner_vld, 0);
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    chk("t6_owner3", owner, 3);
    chk("t6_vld3", owner_vld, 1);
    req_n   = 4'b1111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    chk("t6_end_vld", owner_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
